adc128s022_driver: RTL and testbench

- Single-shot SPI master for the TI ADC128S022 12-bit, 8-channel ADC.
- On a trigger it runs one 16-SCLK frame on a fixed channel and returns the result as a 16-bit word.
- Sits between the pixel-test sequencer and the ADC pins.
- The sequencer sees the frame as CS_N falling then rising, then ships data_out[7:0] and data_out[15:8] over the UART transmitter. The UART transmitter is a separate block with its own spec.

---
 rtl/adc_pkg.sv | 40 ++++
 rtl/adc_sclk_gen.sv | 49 ++++
 rtl/adc128s022_driver.sv | 85 ++++++++
 tb/tb_adc128s022_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC128S022 single-shot SPI driver.
package adc_pkg;

  localparam int unsigned ADC_FRAME_BITS    = 16;
  localparam int unsigned ADC_DATA_BITS     = 12;
  localparam int unsigned ADC_ADDR_BITS     = 3;
  localparam int unsigned ADC_PERIOD_W      = 5;
  localparam int unsigned ADC_SCLK_HALF_DEF = 13;
  localparam logic [ADC_ADDR_BITS-1:0] ADC_CHANNEL_DEF = 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DONE
  } adc_state_e;

  // Result word: conversion bits only, leading frame bits forced to zero.
  function automatic logic [ADC_FRAME_BITS-1:0] adc_result(
    input logic [ADC_FRAME_BITS-1:0] shift
  );
    return {{(ADC_FRAME_BITS - ADC_DATA_BITS){1'b0}}, shift[ADC_DATA_BITS-1:0]};
  endfunction

  // DIN bit for a given SCLK period: channel address MSB-first in periods 2..4.
  function automatic logic adc_addr_bit(
    input logic [ADC_ADDR_BITS-1:0] channel,
    input logic [ADC_PERIOD_W-1:0]  period
  );
    logic bit_v;
    bit_v = 1'b0;
    case (period)
      ADC_PERIOD_W'(2): bit_v = channel[2];
      ADC_PERIOD_W'(3): bit_v = channel[1];
      ADC_PERIOD_W'(4): bit_v = channel[0];
      default:          bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK divider: half-period strobes, SCLK level and period index for one frame.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int unsigned SCLK_HALF = ADC_SCLK_HALF_DEF
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    sclk,
  output logic [ADC_PERIOD_W-1:0] period,
  output logic                    fall_tick_c,
  output logic                    rise_tick_c,
  output logic                    done_tick_c
);

  localparam int unsigned CNT_W = $clog2(SCLK_HALF) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF - 1);
  localparam logic [ADC_PERIOD_W-1:0] PERIODS = ADC_PERIOD_W'(ADC_FRAME_BITS);

  logic [CNT_W-1:0] half_cnt;
  logic             half_tick_c;

  // After the last rising edge one more high half-period closes the frame.
  always_comb begin
    half_tick_c = enable && (half_cnt == CNT_LAST);
    fall_tick_c = half_tick_c && sclk && (period != PERIODS);
    rise_tick_c = half_tick_c && !sclk;
    done_tick_c = half_tick_c && sclk && (period == PERIODS);
  end

  always_ff @(posedge clk_in) begin
    if (reset || !enable) begin
      half_cnt <= '0;
      sclk     <= 1'b1;
      period   <= '0;
    end else begin
      half_cnt <= half_tick_c ? '0 : half_cnt + CNT_W'(1);
      if (fall_tick_c) begin
        sclk <= 1'b0;
      end
      if (rise_tick_c) begin
        sclk   <= 1'b1;
        period <= period + ADC_PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc128s022_driver.sv
// Single-shot SPI master for the ADC128S022: one 16-SCLK frame per trigger on a fixed channel.
module adc128s022_driver
  import adc_pkg::*;
#(
  parameter int unsigned               SCLK_HALF = ADC_SCLK_HALF_DEF,
  parameter logic [ADC_ADDR_BITS-1:0] CHANNEL   = ADC_CHANNEL_DEF
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      start_convert,
  input  logic                      ADC_SDAT,
  output logic                      ADC_SCLK,
  output logic                      ADC_CS_N,
  output logic                      ADC_SADDR,
  output logic [ADC_FRAME_BITS-1:0] data_out
);

  adc_state_e                state;
  logic                      armed;
  logic [ADC_FRAME_BITS-1:0] shift;
  logic [ADC_PERIOD_W-1:0]   period;
  logic                      fall_tick_c;
  logic                      rise_tick_c;
  logic                      done_tick_c;

  adc_sclk_gen #(
    .SCLK_HALF(SCLK_HALF)
  ) u_sclk_gen (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (state == FRAME),
    .sclk        (ADC_SCLK),
    .period      (period),
    .fall_tick_c (fall_tick_c),
    .rise_tick_c (rise_tick_c),
    .done_tick_c (done_tick_c)
  );

  // Level-sampled trigger; armed blocks a held-low request from re-firing.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= IDLE;
      armed     <= 1'b1;
      ADC_CS_N  <= 1'b1;
      ADC_SADDR <= 1'b0;
      shift     <= '0;
      data_out  <= '0;
    end else begin
      if (start_convert) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!start_convert && armed) begin
            ADC_CS_N <= 1'b0;
            armed    <= 1'b0;
            shift    <= '0;
            state    <= FRAME;
          end
        end
        FRAME: begin
          if (fall_tick_c) begin
            ADC_SADDR <= adc_addr_bit(CHANNEL, period);
          end
          if (rise_tick_c) begin
            shift <= {shift[ADC_FRAME_BITS-2:0], ADC_SDAT};
          end
          if (done_tick_c) begin
            ADC_CS_N  <= 1'b1;
            ADC_SADDR <= 1'b0;
            data_out  <= adc_result(shift);
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc128s022_driver.sv
// Scoreboard bench: two drivers (CHANNEL 0 and 5), each talking to a behavioural ADC128S022.
module tb_adc128s022_driver;

  localparam int unsigned HALF       = 2;
  localparam int unsigned FRAME_CLKS = 33 * HALF;

  typedef struct packed {
    logic        abort;
    logic [2:0]  ch;
    logic [15:0] data;
  } exp_t;

  logic            clk_in        = 1'b0;
  logic            reset         = 1'b1;
  logic            start_convert = 1'b1;
  logic [1:0]      cs_mon;
  logic [1:0]      sclk_mon;
  logic [1:0]      saddr_mon;
  logic [1:0][15:0] dout_mon;
  exp_t            pending_exp [2];
  logic [11:0]     chan_val [8];
  logic            ones = 1'b0;
  int              n_checks = 0;
  int              n_pass   = 0;

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam logic [2:0] CH = (gi == 0) ? 3'd0 : 3'd5;

    logic        sclk;
    logic        cs_n;
    logic        saddr;
    logic        sdat       = 1'b0;
    logic [15:0] data_out;
    logic [15:0] dout_sr    = '0;
    logic [15:0] din_word   = '0;
    logic [2:0]  addr_latch = '0;
    logic [2:0]  conv_ch    = '0;
    logic [2:0]  next_ch    = '0;
    int          falls      = 0;
    int          rises      = 0;
    int          low_cycles = 0;
    logic        cs_prev    = 1'b1;
    exp_t        exp_q [$];
    exp_t        e;

    adc128s022_driver #(
      .SCLK_HALF (HALF),
      .CHANNEL   (CH)
    ) u_dut (
      .clk_in        (clk_in),
      .reset         (reset),
      .start_convert (start_convert),
      .ADC_SDAT      (sdat),
      .ADC_SCLK      (sclk),
      .ADC_CS_N      (cs_n),
      .ADC_SADDR     (saddr),
      .data_out      (data_out)
    );

    assign cs_mon[gi]    = cs_n;
    assign sclk_mon[gi]  = sclk;
    assign saddr_mon[gi] = saddr;
    assign dout_mon[gi]  = data_out;

    // ADC model: converts the channel addressed in the previous frame.
    always @(negedge cs_n) begin
      falls    = 0;
      rises    = 0;
      din_word = '0;
      conv_ch  = next_ch;
      dout_sr  = ones ? 16'hFFFF : {4'h0, chan_val[conv_ch]};
    end

    always @(posedge cs_n) begin
      if (rises >= 5) next_ch = addr_latch;
    end

    always @(negedge sclk) begin
      if (!cs_n) begin
        sdat    = dout_sr[15];
        dout_sr = {dout_sr[14:0], 1'b0};
        falls++;
      end
    end

    always @(posedge sclk) begin
      if (!cs_n) begin
        din_word = {din_word[14:0], saddr};
        if (rises >= 2 && rises <= 4) addr_latch = {addr_latch[1:0], saddr};
        rises++;
      end
    end

    // Scoreboard: expectation captured at CS_N fall, compared at CS_N rise.
    always @(negedge clk_in) begin
      if (cs_prev && !cs_n) begin
        exp_q.push_back(pending_exp[gi]);
        low_cycles = 0;
      end
      if (!cs_n) low_cycles++;
      if (!cs_prev && cs_n) begin
        check_eq($sformatf("dut%0d_frame_expected", gi), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq($sformatf("dut%0d_data_out", gi), 32'(data_out), 32'(e.data));
          if (e.abort) begin
            check_eq($sformatf("dut%0d_abort_sclk", gi), 32'(sclk), 32'd1);
          end else begin
            check_eq($sformatf("dut%0d_cs_low_cycles", gi), 32'(low_cycles), 32'(FRAME_CLKS));
            check_eq($sformatf("dut%0d_sclk_falls", gi), 32'(falls), 32'd16);
            check_eq($sformatf("dut%0d_din_word", gi), 32'(din_word), 32'({2'b00, e.ch, 11'd0}));
          end
        end
      end
      cs_prev = cs_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_cs(input logic level, input int limit, input string tag);
    int i;
    i = 0;
    while (cs_mon[0] !== level && i < limit) begin
      @(negedge clk_in);
      i++;
    end
    check_eq(tag, 32'(cs_mon[0]), 32'(level));
  endtask

  task automatic expect_frame(input logic [11:0] v0, input logic [11:0] v5, input logic abort);
    pending_exp[0] = '{abort: abort, ch: 3'd0, data: abort ? 16'h0000 : {4'h0, v0}};
    pending_exp[1] = '{abort: abort, ch: 3'd5, data: abort ? 16'h0000 : {4'h0, v5}};
  endtask

  task automatic pulse_frame(input string tag);
    start_convert = 1'b0;
    @(negedge clk_in);
    start_convert = 1'b1;
    check_eq({tag, "_cs_latency"}, 32'(cs_mon), 32'd0);
    wait_cs(1'b1, 4 * FRAME_CLKS, {tag, "_cs_rise"});
    tick(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_falls;
    logic prev;

    for (int i = 0; i < 8; i++) chan_val[i] = 12'(i * 273);
    chan_val[0] = 12'hABC;
    chan_val[5] = 12'h5A5;
    expect_frame(12'h000, 12'h000, 1'b0);

    reset = 1'b1;
    tick(5);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      check_eq("idle_pins", 32'({cs_mon, sclk_mon, saddr_mon}), 32'(6'b111100));
      check_eq("idle_data", 32'(dout_mon), 32'd0);
    end

    // First frame: CHANNEL=5 part still converts power-up IN0.
    expect_frame(12'hABC, 12'hABC, 1'b0);
    pulse_frame("f1");
    check_eq("f1_hold_dut0", 32'(dout_mon[0]), 32'h0ABC);

    expect_frame(12'hABC, 12'h5A5, 1'b0);
    pulse_frame("f2");
    check_eq("f2_hold_dut5", 32'(dout_mon[1]), 32'h05A5);

    ones = 1'b1;
    expect_frame(12'hFFF, 12'hFFF, 1'b0);
    pulse_frame("f3_ones");
    ones = 1'b0;

    // Held-low request yields one frame; release then re-assert starts another.
    chan_val[0] = 12'h123;
    chan_val[5] = 12'h456;
    expect_frame(12'h123, 12'h456, 1'b0);
    start_convert = 1'b0;
    n_falls = 0;
    prev    = cs_mon[0];
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_in);
      if (prev && !cs_mon[0]) n_falls++;
      prev = cs_mon[0];
    end
    check_eq("hold_low_frames", 32'(n_falls), 32'd1);
    check_eq("hold_low_cs_idle", 32'(cs_mon), 32'd3);
    start_convert = 1'b1;
    @(negedge clk_in);
    start_convert = 1'b0;
    @(negedge clk_in);
    check_eq("rearm_latency", 32'(cs_mon), 32'd0);
    wait_cs(1'b1, 4 * FRAME_CLKS, "rearm_cs_rise");
    start_convert = 1'b1;
    tick(3);

    // Reset during SCLK period 7 aborts the frame.
    expect_frame(12'h000, 12'h000, 1'b1);
    start_convert = 1'b0;
    @(negedge clk_in);
    start_convert = 1'b1;
    n_falls = 0;
    prev    = sclk_mon[0];
    for (int i = 0; i < 4 * FRAME_CLKS && n_falls < 8; i++) begin
      @(negedge clk_in);
      if (prev && !sclk_mon[0]) n_falls++;
      prev = sclk_mon[0];
    end
    check_eq("abort_reached_period7", 32'(n_falls), 32'd8);
    check_eq("abort_prior_data", 32'(dout_mon[0]), 32'h0123);
    reset = 1'b1;
    @(negedge clk_in);
    check_eq("abort_pins", 32'({cs_mon, sclk_mon}), 32'hF);
    check_eq("abort_data", 32'(dout_mon), 32'd0);
    reset = 1'b0;
    tick(3);

    expect_frame(12'h123, 12'h456, 1'b0);
    pulse_frame("f_after_abort");
    check_eq("after_abort_dut5", 32'(dout_mon[1]), 32'h0456);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
